// File: rtl/password_store_arbiter.sv
// password_store_arbiter
//
// Shares a single-port, synchronous-read password store between the password
// setter (write requester) and the password validator (read requester), and
// sequences a bulk clear that rewrites every entry with DEFAULT_DIGIT.
//
// Ports:
//   CLK, RST            clock and synchronous active-high reset
//   wrReq/wrAddr/wrData setter write request; wrGrant (comb) = write done
//   rdReq/rdAddr        validator read request; rdGrant (comb) = address sent
//   rdValid/rdData      read response, one cycle after rdGrant
//   clearReq/clearBusy  bulk clear request (S_IDLE only) / clear in progress
//   memAddress, memWrite, memWriteData, memReadData   store interface
module password_store_arbiter #(
  parameter int          ADDR_WIDTH    = 2,
  parameter int          DATA_WIDTH    = 4,
  parameter int unsigned DEFAULT_DIGIT = 0,
  parameter int          MAX_WAIT      = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wrReq,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic                  wrGrant,
  input  logic                  rdReq,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic                  rdGrant,
  output logic                  rdValid,
  output logic [DATA_WIDTH-1:0] rdData,
  input  logic                  clearReq,
  output logic                  clearBusy,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memWrite,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] memReadData
);

  // waitCount must be able to hold MAX_WAIT; keep at least one bit so a
  // MAX_WAIT of 0 still yields a legal vector (the compare is then always true).
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0]     WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;
  localparam logic [DATA_WIDTH-1:0] CLEAR_DATA = DATA_WIDTH'(DEFAULT_DIGIT);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_index_q, clear_index_d;
  logic [WAIT_W-1:0]     wait_count_q, wait_count_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  wr_grant;
  logic                  rd_grant;
  logic                  clear_busy;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;

  always_comb begin
    state_d        = state_q;
    clear_index_d  = clear_index_q;
    wr_grant       = 1'b0;
    rd_grant       = 1'b0;
    clear_busy     = 1'b0;
    mem_write      = 1'b0;
    // Parking the address on the read port keeps an idle store harmless.
    mem_address    = rdAddr;
    mem_write_data = wrData;

    // All grants and store writes are suppressed while reset is held.
    if (!RST) begin
      case (state_q)
        S_IDLE: begin
          if (clearReq) begin
            state_d       = S_CLEAR;
            clear_index_d = '0;
          end else if (wrReq && rdReq) begin
            // Writes normally win; a read that has lost MAX_WAIT times in a
            // row takes the store so the validator cannot be starved.
            if (wait_count_q >= WAIT_LIMIT) begin
              rd_grant = 1'b1;
            end else begin
              wr_grant = 1'b1;
            end
          end else if (wrReq) begin
            wr_grant = 1'b1;
          end else if (rdReq) begin
            rd_grant = 1'b1;
          end
        end
        S_CLEAR: begin
          clear_busy     = 1'b1;
          mem_address    = clear_index_q;
          mem_write      = 1'b1;
          mem_write_data = CLEAR_DATA;
          clear_index_d  = clear_index_q + 1'b1;
          if (clear_index_q == LAST_INDEX) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (wr_grant) begin
        mem_address    = wrAddr;
        mem_write      = 1'b1;
        mem_write_data = wrData;
      end
    end

    // Counts every cycle a pending read goes unserved, including clear
    // cycles, so a read queued behind a clear wins its first idle cycle.
    if (rdReq && !rd_grant) begin
      wait_count_d = (wait_count_q >= WAIT_LIMIT) ? wait_count_q
                                                  : wait_count_q + 1'b1;
    end else begin
      wait_count_d = '0;
    end

    rd_valid_d = rd_grant;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      clear_index_q <= '0;
      wait_count_q  <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      clear_index_q <= clear_index_d;
      wait_count_q  <= wait_count_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign wrGrant      = wr_grant;
  assign rdGrant      = rd_grant;
  assign rdValid      = rd_valid_q;
  assign rdData       = memReadData;
  assign clearBusy    = clear_busy;
  assign memAddress   = mem_address;
  assign memWrite     = mem_write;
  assign memWriteData = mem_write_data;

endmodule

// File: tb/tb_password_store_arbiter.sv
// Testbench for password_store_arbiter: directed stimulus with hand-computed
// expectations pushed into queues; a negedge monitor pops and compares
// whenever the DUT presents a grant, read data or a clear write.
module tb_password_store_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       wrReq;
  logic [1:0] wrAddr;
  logic [3:0] wrData;
  logic       wrGrant;
  logic       rdReq;
  logic [1:0] rdAddr;
  logic       rdGrant;
  logic       rdValid;
  logic [3:0] rdData;
  logic       clearReq;
  logic       clearBusy;
  logic [1:0] memAddress;
  logic       memWrite;
  logic [3:0] memWriteData;
  logic [3:0] memReadData;

  // Store model: single port, synchronous read.
  logic [3:0] mem [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

  always @(posedge CLK) begin
    if (memWrite) mem[memAddress] <= memWriteData;
    memReadData <= mem[memAddress];
  end

  always #5 CLK = ~CLK;

  password_store_arbiter dut (
    .CLK(CLK), .RST(RST),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrGrant(wrGrant),
    .rdReq(rdReq), .rdAddr(rdAddr), .rdGrant(rdGrant),
    .rdValid(rdValid), .rdData(rdData),
    .clearReq(clearReq), .clearBusy(clearBusy),
    .memAddress(memAddress), .memWrite(memWrite),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  typedef struct {
    logic       is_rd;
    logic [1:0] addr;
    logic [3:0] data;
  } gexp_t;

  gexp_t      grant_q[$];
  logic [3:0] rdata_q[$];
  logic [1:0] clear_q[$];

  int  n_tests = 0;
  int  n_fail  = 0;
  logic done = 1'b0;

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [1:0] wa, input logic [3:0] wd,
                       input logic rd, input logic [1:0] ra, input logic clr);
    wrReq = wr; wrAddr = wa; wrData = wd;
    rdReq = rd; rdAddr = ra; clearReq = clr;
  endtask

  task automatic exp_wr(input logic [1:0] a, input logic [3:0] d);
    gexp_t g;
    g.is_rd = 1'b0; g.addr = a; g.data = d;
    grant_q.push_back(g);
  endtask

  task automatic exp_rd(input logic [1:0] a, input logic [3:0] d);
    gexp_t g;
    g.is_rd = 1'b1; g.addr = a; g.data = 4'h0;
    grant_q.push_back(g);
    rdata_q.push_back(d);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0);
    step();
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_wrGrant", 32'(wrGrant), 32'd0);
      chk("rst_rdGrant", 32'(rdGrant), 32'd0);
      chk("rst_memWrite", 32'(memWrite), 32'd0);
      chk("rst_clearBusy", 32'(clearBusy), 32'd0);
      chk("rst_rdValid", 32'(rdValid), 32'd0);
    end else begin
      if (wrGrant && rdGrant) begin
        chk("single_grant", 32'd2, 32'd1);
      end else if (wrGrant || rdGrant) begin
        if (grant_q.size() == 0) begin
          chk("unexpected_grant", 32'(rdGrant), 32'hEE);
        end else begin
          gexp_t g;
          g = grant_q.pop_front();
          chk("grant_is_rd", 32'(rdGrant), 32'(g.is_rd));
          chk("grant_addr", 32'(memAddress), 32'(g.addr));
          chk("grant_memWrite", 32'(memWrite), 32'(!g.is_rd));
          if (!g.is_rd) chk("grant_wdata", 32'(memWriteData), 32'(g.data));
        end
      end
      if (clearBusy) begin
        if (clear_q.size() == 0) begin
          chk("unexpected_clear", 32'(memAddress), 32'hEE);
        end else begin
          chk("clear_addr", 32'(memAddress), 32'(clear_q.pop_front()));
          chk("clear_memWrite", 32'(memWrite), 32'd1);
          chk("clear_wdata", 32'(memWriteData), 32'd0);
        end
      end
    end
    if (rdValid) begin
      if (rdata_q.size() == 0) begin
        chk("unexpected_rdValid", 32'(rdData), 32'hEE);
      end else begin
        chk("rd_data", 32'(rdData), 32'(rdata_q.pop_front()));
      end
    end
    if (done) begin
      chk("grant_q_drained", 32'(grant_q.size()), 32'd0);
      chk("rdata_q_drained", 32'(rdata_q.size()), 32'd0);
      chk("clear_q_drained", 32'(clear_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    RST = 1'b1;
    drive(1'b1, 2'd0, 4'd5, 1'b1, 2'd1, 1'b0);
    step();
    step();
    step();

    // Reset release with both requests high: write wins first, then the read.
    RST = 1'b0;
    drive(1'b1, 2'd0, 4'd5, 1'b1, 2'd1, 1'b0); exp_wr(2'd0, 4'd5);        step();
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd1, 1'b0); exp_rd(2'd1, 4'hB);        step();
    idle_cycle();

    // Write then read the same address on the next cycle.
    drive(1'b1, 2'd2, 4'd9, 1'b0, 2'd0, 1'b0); exp_wr(2'd2, 4'd9);        step();
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 1'b0); exp_rd(2'd2, 4'd9);        step();
    idle_cycle();

    // Starvation guard: W,W,W,R repeated three times.
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 2'd3, 4'd7, 1'b1, 2'd0, 1'b0);
      if (k % 4 == 3) exp_rd(2'd0, 4'd5);
      else            exp_wr(2'd3, 4'd7);
      step();
    end
    idle_cycle();

    // Preload 0,1,2,9.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v;
      v = (i == 3) ? 4'd9 : 4'(i);
      drive(1'b1, 2'(i), v, 1'b0, 2'd0, 1'b0); exp_wr(2'(i), v);
      step();
    end
    // Read just before the clear returns the pre-clear value.
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd3, 1'b0); exp_rd(2'd3, 4'd9);        step();
    drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1);                            step();
    // Clear cycles; read and write requests raised in the second one.
    drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0); clear_q.push_back(2'd0);   step();
    drive(1'b1, 2'd1, 4'd6, 1'b1, 2'd3, 1'b1); clear_q.push_back(2'd1);   step();
    clear_q.push_back(2'd2);                                              step();
    clear_q.push_back(2'd3);                                              step();
    // First idle cycle: saturated read beats the write.
    drive(1'b1, 2'd1, 4'd6, 1'b1, 2'd3, 1'b0); exp_rd(2'd3, 4'd0);        step();
    drive(1'b1, 2'd1, 4'd6, 1'b0, 2'd0, 1'b0); exp_wr(2'd1, 4'd6);        step();
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd1, 1'b0); exp_rd(2'd1, 4'd6);        step();
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd0, 1'b0); exp_rd(2'd0, 4'd0);        step();
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 1'b0); exp_rd(2'd2, 4'd0);        step();
    idle_cycle();

    // Reset mid-clear: preload 1,2,3,4, clear two entries, then reset.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 4'(i + 1), 1'b0, 2'd0, 1'b0); exp_wr(2'(i), 4'(i + 1));
      step();
    end
    drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1);                            step();
    drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0); clear_q.push_back(2'd0);   step();
    clear_q.push_back(2'd1);                                              step();
    RST = 1'b1;                                                           step();
    RST = 1'b0;
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd0, 1'b0); exp_rd(2'd0, 4'd0);        step();
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd1, 1'b0); exp_rd(2'd1, 4'd0);        step();
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 1'b0); exp_rd(2'd2, 4'd3);        step();
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd3, 1'b0); exp_rd(2'd3, 4'd4);        step();
    // A fresh clear starts again at index 0.
    drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1);                            step();
    drive(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      clear_q.push_back(2'(i));
      step();
    end
    drive(1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 1'b0); exp_rd(2'd2, 4'd0);        step();
    idle_cycle();
    idle_cycle();
    done = 1'b1;
  end

endmodule
